// File: rtl/memory_unit.sv
// Memory pipeline stage: data-memory writes, load extraction, LR/SC reservation, CSR writes, MW_* register.
// Latency: one cycle from EM_* to MW_*; memory writes issue combinationally in the cycle the op is presented.
// Backpressure: DMemWReady_i low on a write raises M_stall_o and holds the request until accepted.
module memory_unit #(
    parameter int RESV_GRAN   = 2,
    parameter bit MISALIGN_WB = 1'b0
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] EM_PC_i,
    input  logic        EM_nop_i,
    input  logic        EM_isLoad_i,
    input  logic        EM_isStore_i,
    input  logic        EM_isAMO_i,
    input  logic        EM_isCSR_i,
    input  logic        EM_isCSRWrite_i,
    input  logic [5:0]  EM_rdId_i,
    input  logic [11:0] EM_csrId_i,
    input  logic [2:0]  EM_funct3_i,
    input  logic [6:0]  EM_funct7_i,
    input  logic [31:0] EM_rs2_i,
    input  logic [31:0] EM_Eresult_i,
    input  logic [31:0] EM_addr_i,
    input  logic [31:0] EM_Mdata_i,
    input  logic [31:0] EM_CSRdata_i,
    input  logic        EM_wbEnable_i,
    output logic        DMemWEn_o,
    output logic [31:0] DMemWAddr_o,
    output logic [31:0] DMemWData_o,
    output logic [3:0]  DMemWMask_o,
    input  logic        DMemWReady_i,
    output logic        csrWEn_o,
    output logic [11:0] csrWAddr_o,
    output logic [31:0] csrWData_o,
    output logic        M_stall_o,
    output logic        M_misalign_o,
    output logic [31:0] MW_PC_o,
    output logic        MW_nop_o,
    output logic        MW_wbEnable_o,
    output logic [5:0]  MW_rdId_o,
    output logic [31:0] MW_wbData_o
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t                 state_q, state_d;
    logic [31:0]            waddr_q, wdata_q;
    logic [3:0]             wmask_q;
    logic                   sc_pass_q;
    logic                   resv_valid_q;
    logic [31-RESV_GRAN:0]  resv_addr_q;

    logic        valid, is_lr, is_sc, is_amo_rmw, is_plain_store, is_mem;
    logic [1:0]  size;
    logic        misaligned, resv_hit, sc_pass, write_op, retire;
    logic [31:0] req_addr, req_data;
    logic [3:0]  req_mask;
    logic [15:0] lane;
    logic [31:0] load_val, wb_data;
    logic        wb_en;
    logic        unused_aqrl;

    // aq/rl ordering bits carry no meaning for a single in-order memory port
    assign unused_aqrl = ^EM_funct7_i[1:0];

    // Decode: atomics are selected by funct7[6:2] (00010 = LR, 00011 = SC, else read-modify-write)
    assign valid          = !EM_nop_i;
    assign is_lr          = EM_isAMO_i && (EM_funct7_i[6:2] == 5'b00010);
    assign is_sc          = EM_isAMO_i && (EM_funct7_i[6:2] == 5'b00011);
    assign is_amo_rmw     = EM_isAMO_i && !is_lr && !is_sc;
    assign is_plain_store = EM_isStore_i && !EM_isAMO_i;
    assign is_mem         = EM_isLoad_i || EM_isStore_i || EM_isAMO_i;
    assign size           = EM_isAMO_i ? 2'b10 : EM_funct3_i[1:0];
    assign misaligned     = valid && is_mem &&
                            (((size == 2'b01) && EM_addr_i[0]) ||
                             ((size == 2'b10) && (EM_addr_i[1:0] != 2'b00)));

    // SC outcome is frozen when the request is latched so a held SC cannot change result mid-wait
    assign resv_hit = resv_valid_q && (EM_addr_i[31:RESV_GRAN] == resv_addr_q);
    assign sc_pass  = (state_q == S_WAIT) ? sc_pass_q : resv_hit;
    assign write_op = valid && !misaligned && (is_plain_store || is_amo_rmw || (is_sc && sc_pass));

    // Byte-lane alignment of the write request
    always_comb begin
        req_addr = {EM_addr_i[31:2], 2'b00};
        req_mask = 4'hF;
        req_data = is_sc ? EM_rs2_i : EM_Eresult_i;
        if (is_plain_store) begin
            case (EM_funct3_i[1:0])
                2'b00: begin
                    req_mask = 4'b0001 << EM_addr_i[1:0];
                    req_data = {4{EM_rs2_i[7:0]}};
                end
                2'b01: begin
                    req_mask = 4'b0011 << EM_addr_i[1:0];
                    req_data = {2{EM_rs2_i[15:0]}};
                end
                default: begin
                    req_mask = 4'hF;
                    req_data = EM_rs2_i;
                end
            endcase
        end
    end

    // Handshake FSM next state and memory-side outputs; outputs forced low while reset is held
    always_comb begin
        state_d     = state_q;
        DMemWEn_o   = 1'b0;
        DMemWAddr_o = 32'h0;
        DMemWData_o = 32'h0;
        DMemWMask_o = 4'h0;
        M_stall_o   = 1'b0;
        if (!reset_i) begin
            case (state_q)
                S_IDLE: begin
                    if (write_op) begin
                        DMemWEn_o   = 1'b1;
                        DMemWAddr_o = req_addr;
                        DMemWData_o = req_data;
                        DMemWMask_o = req_mask;
                        M_stall_o   = !DMemWReady_i;
                        if (!DMemWReady_i) state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    DMemWEn_o   = 1'b1;
                    DMemWAddr_o = waddr_q;
                    DMemWData_o = wdata_q;
                    DMemWMask_o = wmask_q;
                    M_stall_o   = !DMemWReady_i;
                    if (DMemWReady_i) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign retire       = valid && !M_stall_o && !reset_i;
    assign csrWEn_o     = retire && EM_isCSRWrite_i;
    assign csrWAddr_o   = csrWEn_o ? EM_csrId_i : 12'h0;
    assign csrWData_o   = csrWEn_o ? EM_Eresult_i : 32'h0;
    assign M_misalign_o = retire && misaligned;

    // Load lane extraction and writeback data selection
    always_comb begin
        lane = 16'(EM_Mdata_i >> {EM_addr_i[1:0], 3'b000});
        case (EM_funct3_i)
            3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_val = {24'h0, lane[7:0]};
            3'b101:  load_val = {16'h0, lane[15:0]};
            default: load_val = EM_Mdata_i;
        endcase
        if (misaligned)       wb_data = 32'h0;
        else if (EM_isCSR_i)  wb_data = EM_CSRdata_i;
        else if (is_sc)       wb_data = {31'h0, !sc_pass};
        else if (EM_isAMO_i)  wb_data = EM_Mdata_i;
        else if (EM_isLoad_i) wb_data = load_val;
        else                  wb_data = EM_Eresult_i;
        wb_en = EM_wbEnable_i && valid && (EM_rdId_i != 6'd0) && !(misaligned && !MISALIGN_WB);
    end

    // FSM state and latched write request
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            waddr_q   <= 32'h0;
            wdata_q   <= 32'h0;
            wmask_q   <= 4'h0;
            sc_pass_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_q == S_IDLE) && write_op && !DMemWReady_i) begin
                waddr_q   <= req_addr;
                wdata_q   <= req_data;
                wmask_q   <= req_mask;
                sc_pass_q <= resv_hit;
            end
        end
    end

    // LR/SC reservation: set by LR, cleared by any SC or a retiring write to the reserved granule
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            resv_valid_q <= 1'b0;
            resv_addr_q  <= '0;
        end else if (retire && !misaligned) begin
            if (is_lr) begin
                resv_valid_q <= 1'b1;
                resv_addr_q  <= EM_addr_i[31:RESV_GRAN];
            end else if (is_sc || ((is_plain_store || is_amo_rmw) && resv_hit)) begin
                resv_valid_q <= 1'b0;
            end
        end
    end

    // MW_* writeback register; a bubble is inserted while the stage is stalled
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            MW_PC_o       <= 32'h0;
            MW_nop_o      <= 1'b1;
            MW_wbEnable_o <= 1'b0;
            MW_rdId_o     <= 6'h0;
            MW_wbData_o   <= 32'h0;
        end else if (M_stall_o) begin
            MW_nop_o      <= 1'b1;
            MW_wbEnable_o <= 1'b0;
        end else begin
            MW_PC_o       <= EM_PC_i;
            MW_nop_o      <= EM_nop_i;
            MW_wbEnable_o <= wb_en;
            MW_rdId_o     <= EM_rdId_i;
            MW_wbData_o   <= wb_data;
        end
    end

endmodule

// File: tb/tb_memory_unit.sv
// Self-checking bench for memory_unit: scoreboard of expected MW_* retires plus per-test memory/CSR checks.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Backpressure is exercised by holding DMemWReady_i low for a fixed number of cycles.
module tb_memory_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] EM_PC, EM_rs2, EM_Eresult, EM_addr, EM_Mdata, EM_CSRdata;
    logic        EM_nop, EM_isLoad, EM_isStore, EM_isAMO, EM_isCSR, EM_isCSRWrite, EM_wbEnable;
    logic [5:0]  EM_rdId;
    logic [11:0] EM_csrId;
    logic [2:0]  EM_funct3;
    logic [6:0]  EM_funct7;
    logic        DMemWEn, DMemWReady, csrWEn, M_stall, M_misalign;
    logic [31:0] DMemWAddr, DMemWData, csrWData, MW_PC, MW_wbData;
    logic [3:0]  DMemWMask;
    logic [11:0] csrWAddr;
    logic        MW_nop, MW_wbEnable;
    logic [5:0]  MW_rdId;

    typedef struct {
        logic [31:0] pc;
        logic        wben;
        logic [5:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    localparam logic [6:0] F7_LR  = 7'b0001000;
    localparam logic [6:0] F7_SC  = 7'b0001100;
    localparam logic [6:0] F7_ADD = 7'b0000000;

    memory_unit dut (
        .clk_i(clk), .reset_i(rst),
        .EM_PC_i(EM_PC), .EM_nop_i(EM_nop), .EM_isLoad_i(EM_isLoad), .EM_isStore_i(EM_isStore),
        .EM_isAMO_i(EM_isAMO), .EM_isCSR_i(EM_isCSR), .EM_isCSRWrite_i(EM_isCSRWrite),
        .EM_rdId_i(EM_rdId), .EM_csrId_i(EM_csrId), .EM_funct3_i(EM_funct3), .EM_funct7_i(EM_funct7),
        .EM_rs2_i(EM_rs2), .EM_Eresult_i(EM_Eresult), .EM_addr_i(EM_addr), .EM_Mdata_i(EM_Mdata),
        .EM_CSRdata_i(EM_CSRdata), .EM_wbEnable_i(EM_wbEnable),
        .DMemWEn_o(DMemWEn), .DMemWAddr_o(DMemWAddr), .DMemWData_o(DMemWData), .DMemWMask_o(DMemWMask),
        .DMemWReady_i(DMemWReady),
        .csrWEn_o(csrWEn), .csrWAddr_o(csrWAddr), .csrWData_o(csrWData),
        .M_stall_o(M_stall), .M_misalign_o(M_misalign),
        .MW_PC_o(MW_PC), .MW_nop_o(MW_nop), .MW_wbEnable_o(MW_wbEnable), .MW_rdId_o(MW_rdId),
        .MW_wbData_o(MW_wbData)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Scoreboard: every non-bubble MW_* value must match the oldest expected retire
    always @(negedge clk) begin
        if (!rst && !MW_nop) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL retire_unexpected: got pc=%h wben=%b rd=%0d data=%h, none expected",
                         MW_PC, MW_wbEnable, MW_rdId, MW_wbData);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if ({MW_PC, MW_wbEnable, MW_rdId, MW_wbData} !== {e.pc, e.wben, e.rd, e.data}) begin
                    bad++;
                    $display("FAIL retire: got pc=%h wben=%b rd=%0d data=%h, want pc=%h wben=%b rd=%0d data=%h",
                             MW_PC, MW_wbEnable, MW_rdId, MW_wbData, e.pc, e.wben, e.rd, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bubble();
        EM_nop = 1'b1; EM_isLoad = 0; EM_isStore = 0; EM_isAMO = 0; EM_isCSR = 0; EM_isCSRWrite = 0;
        EM_wbEnable = 0; EM_rdId = 0; EM_csrId = 0; EM_funct3 = 0; EM_funct7 = 0;
        EM_PC = 0; EM_rs2 = 0; EM_Eresult = 0; EM_addr = 0; EM_Mdata = 0; EM_CSRdata = 0;
    endtask

    task automatic issue(input logic [31:0] pc, input logic ld, input logic st, input logic amo,
                         input logic csr, input logic csrw, input logic [5:0] rd, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] rs2, input logic [31:0] eres,
                         input logic [31:0] addr, input logic [31:0] mdata, input logic [31:0] csrdata,
                         input logic wben);
        EM_nop = 1'b0; EM_PC = pc; EM_isLoad = ld; EM_isStore = st; EM_isAMO = amo; EM_isCSR = csr;
        EM_isCSRWrite = csrw; EM_rdId = rd; EM_funct3 = f3; EM_funct7 = f7; EM_rs2 = rs2;
        EM_Eresult = eres; EM_addr = addr; EM_Mdata = mdata; EM_CSRdata = csrdata; EM_wbEnable = wben;
        EM_csrId = 12'h305;
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic wben, input logic [5:0] rd,
                            input logic [31:0] data);
        exp_t e;
        e.pc = pc; e.wben = wben; e.rd = rd; e.data = data;
        sb_q.push_back(e);
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if ({MW_nop, MW_wbEnable, MW_PC, MW_rdId, MW_wbData, DMemWEn, M_stall, csrWEn, M_misalign}
            !== {1'b1, 1'b0, 32'h0, 6'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state: nop=%b wben=%b pc=%h wen=%b stall=%b, want nop=1 rest 0",
                     MW_nop, MW_wbEnable, MW_PC, DMemWEn, M_stall);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_sw();
        issue(32'h1000, 0, 1, 0, 0, 0, 6'd0, 3'b010, 7'h0, 32'hDEADBEEF, 32'h104, 32'h104, 0, 0, 0);
        push_exp(32'h1000, 1'b0, 6'd0, 32'h104);
        @(negedge clk);
        total++;
        if ({DMemWEn, DMemWMask, DMemWAddr, DMemWData, M_stall} !== {1'b1, 4'hF, 32'h104, 32'hDEADBEEF, 1'b0}) begin
            bad++;
            $display("FAIL sw_write: wen=%b mask=%h addr=%h data=%h stall=%b, want 1 f 00000104 deadbeef 0",
                     DMemWEn, DMemWMask, DMemWAddr, DMemWData, M_stall);
        end
        tick();
        bubble();
        @(negedge clk);
        total++;
        if ({DMemWEn, M_stall} !== 2'b00) begin
            bad++;
            $display("FAIL sw_single_cycle: wen=%b stall=%b, want 0 0", DMemWEn, M_stall);
        end
        tick();
    endtask

    task automatic test_sb_backpressure();
        DMemWReady = 1'b0;
        issue(32'h1004, 0, 1, 0, 0, 0, 6'd0, 3'b000, 7'h0, 32'h5A, 32'h103, 32'h103, 0, 0, 0);
        push_exp(32'h1004, 1'b0, 6'd0, 32'h103);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({M_stall, DMemWEn, DMemWMask, DMemWAddr, DMemWData} !== {1'b1, 1'b1, 4'h8, 32'h100, 32'h5A5A5A5A}) begin
                bad++;
                $display("FAIL sb_stall_cycle%0d: stall=%b wen=%b mask=%h addr=%h data=%h, want 1 1 8 00000100 5a5a5a5a",
                         i, M_stall, DMemWEn, DMemWMask, DMemWAddr, DMemWData);
            end
            tick();
        end
        DMemWReady = 1'b1;
        @(negedge clk);
        total++;
        if ({M_stall, DMemWEn, DMemWMask, DMemWData} !== {1'b0, 1'b1, 4'h8, 32'h5A5A5A5A}) begin
            bad++;
            $display("FAIL sb_accept: stall=%b wen=%b mask=%h data=%h, want 0 1 8 5a5a5a5a",
                     M_stall, DMemWEn, DMemWMask, DMemWData);
        end
        tick();
        bubble();
        @(negedge clk);
        total++;
        if ({M_stall, DMemWEn} !== 2'b00) begin
            bad++;
            $display("FAIL sb_release: stall=%b wen=%b, want 0 0", M_stall, DMemWEn);
        end
        tick();
    endtask

    task automatic test_loads();
        logic [2:0]  f3s  [3] = '{3'b000, 3'b100, 3'b001};
        logic [31:0] exps [3] = '{32'hFFFFFFFF, 32'h000000FF, 32'hFFFF80FF};
        for (int i = 0; i < 3; i++) begin
            issue(32'h1010 + 32'(i * 4), 1, 0, 0, 0, 0, 6'd5, f3s[i], 7'h0, 0, 32'h102, 32'h102,
                  32'h80FF1234, 0, 1);
            push_exp(32'h1010 + 32'(i * 4), 1'b1, 6'd5, exps[i]);
            @(negedge clk);
            total++;
            if (DMemWEn !== 1'b0) begin
                bad++;
                $display("FAIL load%0d_no_write: wen=%b, want 0", i, DMemWEn);
            end
            tick();
        end
        bubble();
        tick();
    endtask

    task automatic test_lr_sc();
        issue(32'h1020, 1, 0, 1, 0, 0, 6'd6, 3'b010, F7_LR, 0, 0, 32'h200, 32'h11, 0, 1);
        push_exp(32'h1020, 1'b1, 6'd6, 32'h11);
        tick();
        issue(32'h1024, 0, 0, 1, 0, 0, 6'd7, 3'b010, F7_SC, 32'hCAFE, 0, 32'h200, 0, 0, 1);
        push_exp(32'h1024, 1'b1, 6'd7, 32'h0);
        @(negedge clk);
        total++;
        if ({DMemWEn, DMemWMask, DMemWAddr, DMemWData} !== {1'b1, 4'hF, 32'h200, 32'hCAFE}) begin
            bad++;
            $display("FAIL sc_pass_write: wen=%b mask=%h addr=%h data=%h, want 1 f 00000200 0000cafe",
                     DMemWEn, DMemWMask, DMemWAddr, DMemWData);
        end
        tick();
        issue(32'h1028, 0, 0, 1, 0, 0, 6'd7, 3'b010, F7_SC, 32'hBEEF, 0, 32'h200, 0, 0, 1);
        push_exp(32'h1028, 1'b1, 6'd7, 32'h1);
        @(negedge clk);
        total++;
        if (DMemWEn !== 1'b0) begin
            bad++;
            $display("FAIL sc_fail_no_write: wen=%b, want 0", DMemWEn);
        end
        tick();
        bubble();
        tick();
    endtask

    task automatic test_store_breaks_resv();
        issue(32'h1030, 1, 0, 1, 0, 0, 6'd6, 3'b010, F7_LR, 0, 0, 32'h200, 32'h22, 0, 1);
        push_exp(32'h1030, 1'b1, 6'd6, 32'h22);
        tick();
        issue(32'h1034, 0, 1, 0, 0, 0, 6'd0, 3'b010, 7'h0, 32'h1, 32'h200, 32'h200, 0, 0, 0);
        push_exp(32'h1034, 1'b0, 6'd0, 32'h200);
        tick();
        issue(32'h1038, 0, 0, 1, 0, 0, 6'd7, 3'b010, F7_SC, 32'h2, 0, 32'h200, 0, 0, 1);
        push_exp(32'h1038, 1'b1, 6'd7, 32'h1);
        @(negedge clk);
        total++;
        if (DMemWEn !== 1'b0) begin
            bad++;
            $display("FAIL sc_after_store_no_write: wen=%b, want 0", DMemWEn);
        end
        tick();
        bubble();
        tick();
    endtask

    task automatic test_misalign_amo_csr();
        issue(32'h1040, 1, 0, 0, 0, 0, 6'd10, 3'b001, 7'h0, 0, 32'h101, 32'h101, 32'h12345678, 0, 1);
        push_exp(32'h1040, 1'b0, 6'd10, 32'h0);
        @(negedge clk);
        total++;
        if ({M_misalign, DMemWEn} !== 2'b10) begin
            bad++;
            $display("FAIL misalign_pulse: misalign=%b wen=%b, want 1 0", M_misalign, DMemWEn);
        end
        tick();
        issue(32'h1044, 0, 0, 1, 0, 0, 6'd8, 3'b010, F7_ADD, 32'h3, 32'h8, 32'h300, 32'h5, 0, 1);
        push_exp(32'h1044, 1'b1, 6'd8, 32'h5);
        @(negedge clk);
        total++;
        if ({M_misalign, DMemWEn, DMemWMask, DMemWAddr, DMemWData} !== {1'b0, 1'b1, 4'hF, 32'h300, 32'h8}) begin
            bad++;
            $display("FAIL amoadd_write: misalign=%b wen=%b mask=%h addr=%h data=%h, want 0 1 f 00000300 00000008",
                     M_misalign, DMemWEn, DMemWMask, DMemWAddr, DMemWData);
        end
        tick();
        issue(32'h1048, 0, 0, 0, 1, 1, 6'd9, 3'b001, 7'h0, 0, 32'h1234, 0, 0, 32'h99, 1);
        push_exp(32'h1048, 1'b1, 6'd9, 32'h99);
        @(negedge clk);
        total++;
        if ({csrWEn, csrWAddr, csrWData, DMemWEn} !== {1'b1, 12'h305, 32'h1234, 1'b0}) begin
            bad++;
            $display("FAIL csr_write: en=%b addr=%h data=%h wen=%b, want 1 305 00001234 0",
                     csrWEn, csrWAddr, csrWData, DMemWEn);
        end
        tick();
        bubble();
        @(negedge clk);
        total++;
        if (csrWEn !== 1'b0) begin
            bad++;
            $display("FAIL csr_pulse_end: en=%b, want 0", csrWEn);
        end
        tick();
    endtask

    task automatic test_reset_in_wait();
        issue(32'h1050, 1, 0, 1, 0, 0, 6'd6, 3'b010, F7_LR, 0, 0, 32'h400, 32'h77, 0, 1);
        push_exp(32'h1050, 1'b1, 6'd6, 32'h77);
        tick();
        DMemWReady = 1'b0;
        issue(32'h1054, 0, 1, 0, 0, 0, 6'd0, 3'b010, 7'h0, 32'h55, 32'h500, 32'h500, 0, 0, 0);
        tick();
        rst = 1'b1;
        #1;
        total++;
        if ({DMemWEn, M_stall, MW_nop} !== 3'b001) begin
            bad++;
            $display("FAIL reset_in_wait: wen=%b stall=%b nop=%b, want 0 0 1", DMemWEn, M_stall, MW_nop);
        end
        bubble();
        DMemWReady = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        issue(32'h1058, 0, 0, 1, 0, 0, 6'd7, 3'b010, F7_SC, 32'h9, 0, 32'h400, 0, 0, 1);
        push_exp(32'h1058, 1'b1, 6'd7, 32'h1);
        @(negedge clk);
        total++;
        if (DMemWEn !== 1'b0) begin
            bad++;
            $display("FAIL resv_cleared_by_reset: wen=%b, want 0", DMemWEn);
        end
        tick();
        bubble();
        tick();
        tick();
    endtask

    initial begin
        bubble();
        DMemWReady = 1'b1;
        test_reset();
        test_sw();
        test_sb_backpressure();
        test_loads();
        test_lr_sc();
        test_store_breaks_resv();
        test_misalign_amo_csr();
        test_reset_in_wait();
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d retires missing, want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
